// File: rtl/demux_stream_1xn_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer: default sizes,
// the select-width helper and the drop-counter type.
package demux_pkg;

  localparam int DEMUX_DEF_DATA_W = 4;
  localparam int DEMUX_DEF_NUM_CH = 16;
  localparam int DEMUX_DEF_CNT_W  = 8;

  // Select width; never below one bit so a two-channel demux still has a select.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [DEMUX_DEF_CNT_W-1:0] drop_cnt_t;

endpackage

// File: rtl/demux_stream_1xn_if.sv
// Stream bundle between the single producer, the demux and its NUM_CH sinks.
// The master side is the producer/sink environment, the slave side is the demux.
interface demux_stream_1xn_if
  import demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DEF_DATA_W,
  parameter int NUM_CH = DEMUX_DEF_NUM_CH,
  parameter int SEL_W  = clog2_min1(NUM_CH)
);
  logic                           valid_i;
  logic                           ready_o;
  logic [DATA_W-1:0]              data_i;
  logic [SEL_W-1:0]               sel_i;
  logic                           bcast_i;
  logic [NUM_CH-1:0]              valid_o;
  logic [NUM_CH-1:0]              ready_i;
  logic [NUM_CH-1:0][DATA_W-1:0]  data_o;

  modport master (
    output valid_i, data_i, sel_i, bcast_i, ready_i,
    input  ready_o, valid_o, data_o
  );

  modport slave (
    input  valid_i, data_i, sel_i, bcast_i, ready_i,
    output ready_o, valid_o, data_o
  );
endinterface

// File: rtl/demux_stream_1xn_slot.sv
// One-entry output holding slot: loads on request, clears when drained,
// and presents zero data whenever it is empty.
module demux_slot #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] dout
);

  logic              valid_p1;
  logic [DATA_W-1:0] data_p1;

  // Occupancy: a load wins over a drain so refill-while-draining keeps the slot full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid_p1 <= 1'b0;
    else if (load)  valid_p1 <= 1'b1;
    else if (ready) valid_p1 <= 1'b0;
  end

  // Payload only moves on a load; its reset value is hidden by the idle gating below.
  always_ff @(posedge clk) begin
    if (load) data_p1 <= din;
  end

  // ---- stage p1 output ----
  assign valid = valid_p1;
  assign dout  = valid_p1 ? data_p1 : '0;

endmodule

// File: rtl/demux_stream_1xn.sv
// Registered 1-to-NUM_CH stream demultiplexer with unicast and broadcast,
// per-channel holding slots, and a saturating counter for out-of-range selects.
module demux_stream_1xn
  import demux_pkg::*;
#(
  parameter  int DATA_W = DEMUX_DEF_DATA_W,
  parameter  int NUM_CH = DEMUX_DEF_NUM_CH,
  parameter  int CNT_W  = DEMUX_DEF_CNT_W,
  localparam int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  demux_stream_1xn_if.slave    bus,
  output logic                 drop_o,
  output logic [CNT_W-1:0]     drop_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // ---- stage p0: accept decision ----
  logic [NUM_CH-1:0]             free_p0;
  logic [NUM_CH-1:0]             load_p0;
  logic                          sel_ok_p0;
  logic                          accept_p0;
  logic                          drop_p0;
  logic                          ready_p0;
  logic [NUM_CH-1:0]             valid_p1;
  logic [NUM_CH-1:0][DATA_W-1:0] data_p1;

  assign free_p0   = ~valid_p1 | bus.ready_i;
  assign sel_ok_p0 = (32'(bus.sel_i) < NUM_CH);

  // Input ready: broadcast needs every slot free, an illegal select is always swallowed.
  always_comb begin
    ready_p0 = 1'b1;
    if (bus.bcast_i)    ready_p0 = &free_p0;
    else if (sel_ok_p0) ready_p0 = free_p0[bus.sel_i];
  end

  assign bus.ready_o = ready_p0;
  assign accept_p0   = bus.valid_i && ready_p0;
  assign drop_p0     = accept_p0 && !bus.bcast_i && !sel_ok_p0;

  // Per-slot load strobes for the accepted beat.
  always_comb begin
    load_p0 = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (accept_p0 && (bus.bcast_i || (sel_ok_p0 && (bus.sel_i == SEL_W'(k)))))
        load_p0[k] = 1'b1;
    end
  end

  // ---- stage p1: holding slots ----
  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk   (clk_i),
      .rst   (rst_i),
      .load  (load_p0[k]),
      .din   (bus.data_i),
      .ready (bus.ready_i[k]),
      .valid (valid_p1[k]),
      .dout  (data_p1[k])
    );
  end

  assign bus.valid_o = valid_p1;
  assign bus.data_o  = data_p1;

  // Drop pulse and saturating drop count for out-of-range unicast beats.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_o     <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      drop_o <= drop_p0;
      if (drop_p0) drop_cnt_o <= sat_inc(drop_cnt_o);
    end
  end

endmodule
